// File: rtl/led_pattern_ctrl.sv
// Per-LED blink sequencer: latches a colour/timing command and runs ON/OFF phases
// of tick-based length for a programmable repeat count, then pulses done.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | outputs 0, prescaler/counters cleared, waiting for a command
// ON     | latched colour driven; steady when off_time == 0
// OFF    | outputs 0; end of phase closes one ON+OFF cycle
module led_pattern_ctrl #(
    parameter int TICK_CLKS = 3145728,
    parameter int TICK_W    = 22
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_red,
    input  logic [7:0] cmd_green,
    input  logic [7:0] cmd_blue,
    input  logic [7:0] cmd_dc,
    input  logic [7:0] cmd_on_time,
    input  logic [7:0] cmd_off_time,
    input  logic [7:0] cmd_repeat,
    input  logic       stop,
    output logic [7:0] red_value,
    output logic [7:0] green_value,
    output logic [7:0] blue_value,
    output logic [7:0] dc_value,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_t;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CLKS - 1);

    state_t state, state_nxt;

    logic [7:0] red_q, green_q, blue_q, dc_q;
    logic [7:0] on_time_q, off_time_q, repeat_q;

    logic [TICK_W-1:0] presc, presc_nxt;
    logic [7:0]        phase_cnt, phase_nxt;
    logic [7:0]        cycle_cnt, cycle_nxt;
    logic              steady, steady_nxt;
    logic              done_q, done_nxt;

    logic       accept;
    logic       running;
    logic       tick;
    logic [7:0] phase_len;
    logic [7:0] phase_inc;
    logic [7:0] cycle_inc;
    logic       phase_end;

    // stop masks the handshake so an aborting cycle can never accept
    assign cmd_ready = ~stop;
    assign accept    = cmd_valid & ~stop;

    // once steady, the prescaler and phase counter are frozen at 0
    assign running   = (state != S_IDLE) && !steady;
    assign tick      = running && (presc == TICK_LAST);
    assign phase_len = (state == S_OFF) ? off_time_q : on_time_q;
    assign phase_inc = phase_cnt + 8'd1;
    assign cycle_inc = cycle_cnt + 8'd1;
    assign phase_end = tick && (phase_inc == phase_len);

    // command field capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red_q      <= 8'd0;
            green_q    <= 8'd0;
            blue_q     <= 8'd0;
            dc_q       <= 8'd0;
            on_time_q  <= 8'd0;
            off_time_q <= 8'd0;
            repeat_q   <= 8'd0;
        end else if (accept) begin
            red_q      <= cmd_red;
            green_q    <= cmd_green;
            blue_q     <= cmd_blue;
            dc_q       <= cmd_dc;
            on_time_q  <= cmd_on_time;
            off_time_q <= cmd_off_time;
            repeat_q   <= cmd_repeat;
        end
    end

    // state and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            presc     <= '0;
            phase_cnt <= 8'd0;
            cycle_cnt <= 8'd0;
            steady    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            presc     <= presc_nxt;
            phase_cnt <= phase_nxt;
            cycle_cnt <= cycle_nxt;
            steady    <= steady_nxt;
            done_q    <= done_nxt;
        end
    end

    // next-state and counter update
    always_comb begin
        state_nxt  = state;
        presc_nxt  = presc;
        phase_nxt  = phase_cnt;
        cycle_nxt  = cycle_cnt;
        steady_nxt = steady;
        done_nxt   = 1'b0;

        if (stop) begin
            state_nxt  = S_IDLE;
            presc_nxt  = '0;
            phase_nxt  = 8'd0;
            cycle_nxt  = 8'd0;
            steady_nxt = 1'b0;
        end else if (accept) begin
            presc_nxt  = '0;
            phase_nxt  = 8'd0;
            cycle_nxt  = 8'd0;
            steady_nxt = 1'b0;
            if (cmd_on_time == 8'd0) begin
                state_nxt = S_IDLE;
                done_nxt  = 1'b1;
            end else begin
                state_nxt = S_ON;
            end
        end else begin
            if (running) begin
                presc_nxt = tick ? '0 : presc + TICK_W'(1);
                if (tick) begin
                    phase_nxt = phase_inc;
                end
            end

            unique case (state)
                S_IDLE: begin
                    state_nxt = S_IDLE;
                end
                S_ON: begin
                    if (phase_end) begin
                        phase_nxt = 8'd0;
                        if (off_time_q == 8'd0) begin
                            steady_nxt = 1'b1;
                        end else begin
                            state_nxt = S_OFF;
                        end
                    end
                end
                S_OFF: begin
                    if (phase_end) begin
                        phase_nxt = 8'd0;
                        cycle_nxt = cycle_inc;
                        if ((repeat_q != 8'd0) && (cycle_inc == repeat_q)) begin
                            state_nxt = S_IDLE;
                            presc_nxt = '0;
                            cycle_nxt = 8'd0;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = S_ON;
                        end
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // outputs decode from registered state, so they change on the accepting edge
    always_comb begin
        red_value   = 8'd0;
        green_value = 8'd0;
        blue_value  = 8'd0;
        dc_value    = 8'd0;
        if (state == S_ON) begin
            red_value   = red_q;
            green_value = green_q;
            blue_value  = blue_q;
            dc_value    = dc_q;
        end
        busy = (state != S_IDLE);
        done = done_q;
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl with a 4-clock tick; expected values
// are hand-derived per sample cycle after each accepting edge.
module tb_led_pattern_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_red, cmd_green, cmd_blue, cmd_dc;
    logic [7:0] cmd_on_time, cmd_off_time, cmd_repeat;
    logic       stop;
    logic [7:0] red_value, green_value, blue_value, dc_value;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    led_pattern_ctrl #(.TICK_CLKS(4), .TICK_W(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_red      (cmd_red),
        .cmd_green    (cmd_green),
        .cmd_blue     (cmd_blue),
        .cmd_dc       (cmd_dc),
        .cmd_on_time  (cmd_on_time),
        .cmd_off_time (cmd_off_time),
        .cmd_repeat   (cmd_repeat),
        .stop         (stop),
        .red_value    (red_value),
        .green_value  (green_value),
        .blue_value   (blue_value),
        .dc_value     (dc_value),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] exp_color,
                             input logic exp_busy, input logic exp_done);
        check({tag, "_color"}, {red_value, green_value, blue_value, dc_value}, exp_color);
        check({tag, "_busy"}, {31'd0, busy}, {31'd0, exp_busy});
        check({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
        if (done === 1'b1) n_done++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] color, input logic [7:0] on_t,
                        input logic [7:0] off_t, input logic [7:0] rep);
        {cmd_red, cmd_green, cmd_blue, cmd_dc} = color;
        cmd_on_time  = on_t;
        cmd_off_time = off_t;
        cmd_repeat   = rep;
    endtask

    task automatic send(input logic [31:0] color, input logic [7:0] on_t,
                        input logic [7:0] off_t, input logic [7:0] rep);
        load(color, on_t, off_t, rep);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_c;
        logic        exp_b;
        logic        exp_d;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        stop      = 1'b0;
        load(32'h0, 8'd0, 8'd0, 8'd0);
        step();
        step();
        check_out("rst_hold", 32'h0, 1'b0, 1'b0);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        rst_n = 1'b1;
        step();
        check_out("rst_rel", 32'h0, 1'b0, 1'b0);

        // blink: 8 on, 4 off, 8 on, 4 off, done at sample 25
        send(32'hFF80_0040, 8'd2, 8'd1, 8'd2);
        n_done = 0;
        for (int k = 1; k <= 30; k++) begin
            exp_c = ((k <= 8) || (k >= 13 && k <= 20)) ? 32'hFF80_0040 : 32'h0;
            exp_b = (k <= 24);
            exp_d = (k == 25);
            check_out($sformatf("blink%0d", k), exp_c, exp_b, exp_d);
            step();
        end
        check("blink_done_cnt", n_done, 32'd1);

        // steady on
        send(32'h1020_30FF, 8'd1, 8'd0, 8'd0);
        n_done = 0;
        for (int k = 1; k <= 200; k++) begin
            check_out($sformatf("steady%0d", k), 32'h1020_30FF, 1'b1, 1'b0);
            step();
        end
        check("steady_done_cnt", n_done, 32'd0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_out("steady_stop", 32'h0, 1'b0, 1'b0);

        // zero on_time completes immediately
        send(32'hAABB_CCDD, 8'd0, 8'd5, 8'd1);
        check_out("zero_on1", 32'h0, 1'b0, 1'b1);
        step();
        for (int k = 2; k <= 6; k++) begin
            check_out($sformatf("zero_on%0d", k), 32'h0, 1'b0, 1'b0);
            step();
        end

        // preempt A during its ON phase with B
        send(32'hAABB_CCDD, 8'd3, 8'd3, 8'd1);
        n_done = 0;
        for (int k = 1; k <= 5; k++) begin
            check_out($sformatf("preA%0d", k), 32'hAABB_CCDD, 1'b1, 1'b0);
            if (k < 5) step();
        end
        send(32'h0102_0300, 8'd1, 8'd1, 8'd1);
        for (int j = 1; j <= 16; j++) begin
            exp_c = (j <= 4) ? 32'h0102_0300 : 32'h0;
            check_out($sformatf("preB%0d", j), exp_c, (j <= 8), (j == 9));
            step();
        end
        check("preempt_done_cnt", n_done, 32'd1);

        // stop beats a simultaneous command during OFF
        send(32'h1122_3344, 8'd1, 8'd2, 8'd0);
        n_done = 0;
        for (int k = 1; k <= 6; k++) begin
            exp_c = (k <= 4) ? 32'h1122_3344 : 32'h0;
            check_out($sformatf("stopC%0d", k), exp_c, 1'b1, 1'b0);
            if (k < 6) step();
        end
        load(32'h5566_7788, 8'd5, 8'd1, 8'd0);
        stop      = 1'b1;
        cmd_valid = 1'b1;
        #1;
        check("stop_ready", {31'd0, cmd_ready}, 32'd0);
        @(posedge clk);
        #1;
        stop      = 1'b0;
        cmd_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            check_out($sformatf("stop_idle%0d", k), 32'h0, 1'b0, 1'b0);
            step();
        end
        check("stop_done_cnt", n_done, 32'd0);

        // asynchronous reset in the middle of ON
        send(32'h5A6B_7C8D, 8'd3, 8'd1, 8'd0);
        for (int k = 1; k <= 5; k++) begin
            check_out($sformatf("rstD%0d", k), 32'h5A6B_7C8D, 1'b1, 1'b0);
            step();
        end
        #($urandom_range(1, 3));
        rst_n = 1'b0;
        #1;
        check_out("mid_rst", 32'h0, 1'b0, 1'b0);
        check("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            check_out($sformatf("post_rst%0d", k), 32'h0, 1'b0, 1'b0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
- Per-LED pattern sequencer. Accepts blink commands from the host register block and drives the 8-bit red/green/blue/DC value inputs of the RGB PWM LED driver.
- Runs ON/OFF phases of programmable length for a programmable number of repeats, or holds steady. Signals completion.
- One instance per RGB LED (three on the board). All instances share clk.

Parameters:
- TICK_CLKS, 3145728, clocks per time tick (≈0.131 s at 24 MHz). Benches override with a small value (e.g. 4).
- TICK_W, 22, width of the tick prescaler; must hold TICK_CLKS-1.

Ports:
- clk  in  1  system clock (24 MHz)
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command strobe
- cmd_ready  out  1  command can be accepted; combinational = ~stop
- cmd_red  in  8  red code for ON phase
- cmd_green  in  8  green code for ON phase
- cmd_blue  in  8  blue code for ON phase
- cmd_dc  in  8  brightness duty-cycle code for ON phase
- cmd_on_time  in  8  ON phase length in ticks
- cmd_off_time  in  8  OFF phase length in ticks
- cmd_repeat  in  8  ON+OFF cycles to run; 0 = infinite
- stop  in  1  synchronous abort to IDLE
- red_value  out  8  to LED driver
- green_value  out  8  to LED driver
- blue_value  out  8  to LED driver
- dc_value  out  8  to LED driver
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at normal pattern completion

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; all value outputs = 0; busy = 0; done = 0.
  - Prescaler, phase counter and cycle counter = 0.
- Accept:
  - A command is accepted when cmd_valid && cmd_ready. It is accepted in any state; a new command preempts the running one.
  - On accept, all cmd_* fields are latched, and the prescaler, phase counter and cycle counter are cleared.
- Latency: registered outputs reflect the new state on the clock edge that accepts the command (visible in the following cycle).
- States: IDLE, ON, OFF.
- Accept with on_time == 0:
  - Go to IDLE; outputs = 0; done = 1 for one cycle.
- Accept with on_time != 0:
  - Go to ON; outputs = latched red/green/blue/dc.
- Tick: prescaler counts 0..TICK_CLKS-1 and wraps. A tick is asserted on the wrap cycle. The prescaler runs only in ON/OFF.
- Phase counter: increments on each tick, is cleared on every phase change, and is compared with the current phase length.
- ON:
  - Lasts exactly on_time*TICK_CLKS cycles.
  - At the end, if off_time == 0, stay in ON (steady on, never completes, counters hold at 0). Otherwise go to OFF with outputs = 0.
- OFF:
  - Lasts exactly off_time*TICK_CLKS cycles.
  - At the end, cycle counter += 1 (8-bit).
  - If repeat != 0 and the new count == repeat: go to IDLE; done = 1 for one cycle (same edge as the IDLE entry); outputs remain 0.
  - Otherwise go to ON with the latched color.
- repeat == 0: infinite; the cycle counter wraps at 255 with no effect.
- IDLE: outputs 0; busy 0; done 0 except the completion pulse.
- stop:
  - Synchronous; takes priority over everything including cmd_valid (cmd_ready = 0 while stop = 1).
  - Next edge: IDLE, outputs 0, counters 0, no done pulse.
- Simultaneous completion and new accept: the accept wins; no done pulse.
- Mid-operation reset: immediate return to reset values; latched command discarded.
- Arithmetic: unsigned compares only; no multipliers.

Test Plan:
- Reset: rst_n = 0 at random time mid-ON -> next sample all values 0, busy 0, done 0, cmd_ready 1; hold 10 cycles unchanged after release.
- Blink (TICK_CLKS = 4): red 0xFF, green 0x80, blue 0x00, dc 0x40, on 2, off 1, repeat 2 -> the full sequence below:
  - Outputs FF/80/00/40 for 8 cycles, then 0 for 4, then FF/80/00/40 for 8, then 0 for 4.
  - done high exactly 1 cycle at the end; busy high for 24 cycles and low afterwards.
- Steady on: on 1, off 0, repeat 0, color 10/20/30 dc FF -> outputs constant 10/20/30/FF for 200 cycles; busy 1; done never asserts.
- Zero on_time: on 0, off 5 -> outputs stay 0, busy 0, done pulse exactly 1 cycle after the accept edge.
- Preempt: cmd A (on 3, off 3, repeat 1) running; at cycle 5 accept cmd B color 01/02/03 on 1 off 1 repeat 1 -> next cycle outputs 01/02/03, B's 4 ON cycles start from 0, one done at B's end, none for A.
- Stop priority: stop = 1 and cmd_valid = 1 same cycle during OFF -> cmd_ready 0, next cycle IDLE, outputs 0, busy 0, no done; the command is ignored.
